// File: rtl/hdmi_audio_pkg.sv
// Shared definitions for the HDMI audio path: sample-rate encodings, default N
// values and helpers that map a rate selection to its N and ACR window length.
package hdmi_audio_pkg;

    typedef enum logic [1:0] {
        RATE_32K     = 2'd0,
        RATE_44K     = 2'd1,
        RATE_48K     = 2'd2,
        RATE_48K_ALT = 2'd3
    } rate_e;

    typedef enum logic [1:0] {
        ST_PRIME,
        ST_FIRST,
        ST_RUN
    } acr_state_e;

    localparam int unsigned N_32K_DEFAULT     = 4096;
    localparam int unsigned N_44K_DEFAULT     = 6272;
    localparam int unsigned N_48K_DEFAULT     = 6144;
    localparam int unsigned CTS_FIXED_DEFAULT = 27000;
    localparam int unsigned N_PERIOD_SHIFT    = 7;

    // Code 3 is not a real rate; it falls through to 48 kHz.
    function automatic logic [31:0] n_for_rate(input logic [1:0] rate,
                                               input logic [31:0] n32,
                                               input logic [31:0] n44,
                                               input logic [31:0] n48);
        if (rate == RATE_32K) return n32;
        if (rate == RATE_44K) return n44;
        return n48;
    endfunction

    function automatic logic [31:0] window_period(input logic [31:0] n);
        return n >> N_PERIOD_SHIFT;
    endfunction

endpackage

// File: rtl/acr_cts_meter.sv
// Counts pixel clock enables over one ACR window and decides the CTS value to
// publish, with saturation detection and a hysteresis band against jitter.
module acr_cts_meter
    import hdmi_audio_pkg::*;
#(
    parameter int CNT_BITS = 20,
    parameter int CTS_TOL  = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear,
    input  logic                capture,
    input  logic                pix_clken,
    input  logic                force_load,
    input  logic [CNT_BITS-1:0] prev_cts,
    output logic [CNT_BITS-1:0] cts_next,
    output logic                m_sat
);

    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    logic [CNT_BITS-1:0] pix_cnt;
    logic [CNT_BITS-1:0] m_value;
    logic [CNT_BITS-1:0] diff;
    logic                pix_inc;

    assign pix_inc = pix_clken && (pix_cnt != CNT_MAX);

    // The closing-cycle pixel pulse belongs to the window being closed,
    // so the counter restarts at zero rather than one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_cnt <= '0;
        end else if (clear || capture) begin
            pix_cnt <= '0;
        end else if (pix_inc) begin
            pix_cnt <= pix_cnt + CNT_BITS'(1);
        end
    end

    // A stopped pixel clock (zero) is as untrustworthy as a pinned counter.
    always_comb begin
        m_value  = pix_inc ? pix_cnt + CNT_BITS'(1) : pix_cnt;
        m_sat    = (m_value == CNT_MAX) || (m_value == '0);
        diff     = (m_value >= prev_cts) ? m_value - prev_cts : prev_cts - m_value;
        cts_next = prev_cts;
        if (m_sat) begin
            cts_next = CNT_MAX;
        end else if (force_load || (diff > CNT_BITS'(CTS_TOL))) begin
            cts_next = m_value;
        end
    end

endmodule

// File: rtl/hdmi_acr_gen.sv
// HDMI audio clock regeneration: emits the ACR strobe every N/128 audio samples
// together with N and a fixed or measured CTS.
module hdmi_acr_gen
    import hdmi_audio_pkg::*;
#(
    parameter int unsigned N_32K     = N_32K_DEFAULT,
    parameter int unsigned N_44K     = N_44K_DEFAULT,
    parameter int unsigned N_48K     = N_48K_DEFAULT,
    parameter int unsigned CTS_FIXED = CTS_FIXED_DEFAULT,
    parameter int          CNT_BITS  = 20,
    parameter int          CTS_TOL   = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [1:0]          rate_sel,
    input  logic                cts_mode,
    input  logic                pcm_clken,
    input  logic                pix_clken,
    output logic                acr,
    output logic [CNT_BITS-1:0] acr_n,
    output logic [CNT_BITS-1:0] acr_cts,
    output logic                acr_valid
);

    logic [1:0]          rate_q;
    logic                cts_mode_q;
    acr_state_e          state;
    logic [CNT_BITS-1:0] samp_cnt;
    logic [CNT_BITS-1:0] n_sel;
    logic [CNT_BITS-1:0] samp_last;
    logic [CNT_BITS-1:0] cts_next;
    logic                m_sat;
    logic                restart;
    logic                close;
    logic                publish;

    assign n_sel     = CNT_BITS'(n_for_rate(rate_sel, N_32K, N_44K, N_48K));
    assign samp_last = CNT_BITS'(window_period(32'(n_sel)) - 32'd1);
    assign restart   = !enable || (rate_sel != rate_q) || (cts_mode != cts_mode_q);
    assign close     = !restart && pcm_clken && (samp_cnt == samp_last);
    // In measured mode the first window after a restart is partial and is dropped.
    assign publish   = close && !((state == ST_PRIME) && cts_mode);

    acr_cts_meter #(
        .CNT_BITS (CNT_BITS),
        .CTS_TOL  (CTS_TOL)
    ) u_meter (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (restart),
        .capture    (close),
        .pix_clken  (pix_clken),
        .force_load (state == ST_FIRST),
        .prev_cts   (acr_cts),
        .cts_next   (cts_next),
        .m_sat      (m_sat)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rate_q     <= RATE_48K;
            cts_mode_q <= 1'b0;
            state      <= ST_PRIME;
            samp_cnt   <= '0;
            acr        <= 1'b0;
            acr_n      <= CNT_BITS'(N_48K);
            acr_cts    <= CNT_BITS'(CTS_FIXED);
            acr_valid  <= 1'b0;
        end else begin
            rate_q     <= rate_sel;
            cts_mode_q <= cts_mode;
            acr        <= publish;
            if (restart) begin
                samp_cnt  <= '0;
                state     <= ST_PRIME;
                acr_valid <= 1'b0;
                acr_n     <= n_sel;
            end else if (pcm_clken) begin
                if (close) begin
                    samp_cnt <= '0;
                    state    <= ((state == ST_PRIME) && cts_mode) ? ST_FIRST : ST_RUN;
                end else begin
                    samp_cnt <= samp_cnt + CNT_BITS'(1);
                end
            end
            if (publish) begin
                acr_n <= n_sel;
                if (cts_mode) begin
                    acr_cts   <= cts_next;
                    acr_valid <= !m_sat;
                end else begin
                    acr_cts   <= CNT_BITS'(CTS_FIXED);
                    acr_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hdmi_acr_gen.sv
// Scoreboard bench for hdmi_acr_gen: directed sample/pixel patterns with
// hand-computed ACR results, checked by an independent strobe monitor.
module tb_hdmi_acr_gen;

    localparam int CNT_BITS = 20;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                enable;
    logic [1:0]          rate_sel;
    logic                cts_mode;
    logic                pcm_clken;
    logic                pix_clken;
    logic                acr;
    logic [CNT_BITS-1:0] acr_n;
    logic [CNT_BITS-1:0] acr_cts;
    logic                acr_valid;

    typedef struct {
        int cyc;
        int n;
        int cts;
        int valid;
    } exp_t;

    exp_t expQ[$];
    exp_t monExp;
    int   checksTotal  = 0;
    int   checksPassed = 0;
    int   cyc          = 0;
    int   pixSel       = 1;
    logic prevAcr      = 1'b0;

    hdmi_acr_gen dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .rate_sel  (rate_sel),
        .cts_mode  (cts_mode),
        .pcm_clken (pcm_clken),
        .pix_clken (pix_clken),
        .acr       (acr),
        .acr_n     (acr_n),
        .acr_cts   (acr_cts),
        .acr_valid (acr_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checksTotal++;
        if (actual == expected) checksPassed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    endtask

    // Strobe monitor: every acr must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset_n) begin
            if (prevAcr) checkOutput("acr_width", int'(acr), 0);
            if (acr) begin
                if (expQ.size() == 0) begin
                    checksTotal++;
                    $display("[TB] FAIL unexpected_acr: got strobe at cycle %0d, expected none", cyc);
                end else begin
                    monExp = expQ.pop_front();
                    checkOutput("acr_cycle", cyc, monExp.cyc);
                    checkOutput("acr_n", int'(acr_n), monExp.n);
                    checkOutput("acr_cts", int'(acr_cts), monExp.cts);
                    checkOutput("acr_valid", int'(acr_valid), monExp.valid);
                end
            end
            prevAcr = acr;
        end else begin
            prevAcr = 1'b0;
        end
    end

    task automatic idleCycle();
        @(negedge clk);
        pcm_clken = 1'b0;
        pix_clken = (pixSel == 1);
    endtask

    // One audio sample: gap-1 quiet cycles then the pcm_clken pulse.
    task automatic sendSample(input int gap);
        for (int k = 0; k < gap; k++) begin
            @(negedge clk);
            pcm_clken = (k == gap - 1);
            pix_clken = (pixSel == 1) || ((pixSel == 2) && (k == gap - 1));
        end
    endtask

    // A whole window of samples; the strobe is due one cycle after the last pulse.
    task automatic applyStimulus(input int samples, input int gapA, input int gapB,
                                 input int firstGap, input bit expectAcr,
                                 input int n, input int cts, input int valid);
        for (int i = 0; i < samples; i++)
            sendSample((i == 0) ? firstGap : ((i % 2) ? gapB : gapA));
        if (expectAcr) expQ.push_back('{cyc + 1, n, cts, valid});
    endtask

    initial begin
        reset_n   = 1'b0;
        enable    = 1'b1;
        rate_sel  = 2'd2;
        cts_mode  = 1'b0;
        pcm_clken = 1'b0;
        pix_clken = 1'b1;
        #12;
        checkOutput("reset_acr", int'(acr), 0);
        checkOutput("reset_acr_n", int'(acr_n), 6144);
        checkOutput("reset_acr_cts", int'(acr_cts), 27000);
        checkOutput("reset_acr_valid", int'(acr_valid), 0);
        @(negedge clk);
        reset_n = 1'b1;

        $display("[TB] 48k fixed CTS");
        applyStimulus(48, 10, 10, 10, 1'b1, 6144, 27000, 1);
        applyStimulus(48, 10, 10, 10, 1'b1, 6144, 27000, 1);

        $display("[TB] 48k measured CTS and hysteresis");
        idleCycle();
        cts_mode = 1'b1;
        idleCycle();
        checkOutput("mode_restart_valid", int'(acr_valid), 0);
        applyStimulus(48, 10, 10, 10, 1'b0, 0, 0, 0);
        applyStimulus(48, 10, 10, 10, 1'b1, 6144, 480, 1);
        applyStimulus(48, 10, 11, 10, 1'b1, 6144, 504, 1);
        applyStimulus(48, 10, 10, 10, 1'b1, 6144, 480, 1);
        applyStimulus(48, 10, 10, 11, 1'b1, 6144, 480, 1);
        applyStimulus(48, 10, 10, 9,  1'b1, 6144, 480, 1);
        applyStimulus(48, 10, 10, 12, 1'b1, 6144, 480, 1);
        applyStimulus(48, 10, 10, 20, 1'b1, 6144, 490, 1);
        pixSel = 2;
        applyStimulus(48, 10, 10, 10, 1'b1, 6144, 48, 1);
        pixSel = 1;
        applyStimulus(48, 10, 10, 13, 1'b1, 6144, 483, 1);

        $display("[TB] rate change 48k to 44.1k mid-window");
        for (int i = 0; i < 20; i++) sendSample(10);
        idleCycle();
        rate_sel = 2'd1;
        idleCycle();
        checkOutput("rate_restart_n", int'(acr_n), 6272);
        checkOutput("rate_restart_valid", int'(acr_valid), 0);
        applyStimulus(49, 10, 10, 10, 1'b0, 0, 0, 0);
        applyStimulus(49, 10, 10, 4,  1'b1, 6272, 484, 1);
        applyStimulus(49, 10, 10, 10, 1'b1, 6272, 490, 1);

        $display("[TB] async reset mid-window, stopped pixel clock");
        for (int i = 0; i < 10; i++) sendSample(10);
        idleCycle();
        #2 reset_n = 1'b0;
        #1;
        checkOutput("async_acr", int'(acr), 0);
        checkOutput("async_acr_n", int'(acr_n), 6144);
        checkOutput("async_acr_cts", int'(acr_cts), 27000);
        checkOutput("async_acr_valid", int'(acr_valid), 0);
        rate_sel  = 2'd2;
        cts_mode  = 1'b1;
        pixSel    = 0;
        pix_clken = 1'b0;
        idleCycle();
        idleCycle();
        reset_n = 1'b1;
        applyStimulus(48, 10, 10, 10, 1'b0, 0, 0, 0);
        applyStimulus(48, 10, 10, 10, 1'b1, 6144, 1048575, 0);
        pixSel = 1;
        applyStimulus(48, 10, 10, 10, 1'b1, 6144, 480, 1);

        $display("[TB] 32k fixed CTS after mode and rate change");
        idleCycle();
        cts_mode = 1'b0;
        rate_sel = 2'd0;
        idleCycle();
        checkOutput("r32_restart_n", int'(acr_n), 4096);
        checkOutput("r32_restart_valid", int'(acr_valid), 0);
        applyStimulus(32, 10, 10, 10, 1'b1, 4096, 27000, 1);

        $display("[TB] enable low holds counters cleared");
        idleCycle();
        enable = 1'b0;
        idleCycle();
        checkOutput("disable_valid", int'(acr_valid), 0);
        for (int i = 0; i < 40; i++) sendSample(10);
        repeat (20) idleCycle();
        checkOutput("scoreboard_empty", expQ.size(), 0);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
